// File: rtl/pendigits_tnn_pkg.sv
// Shared constants, ternary codes and trained weights
// for the pen-digits ternary classifier.
package pendigits_tnn_pkg;

  localparam int N  = 16;
  localparam int M  = 40;
  localparam int B  = 4;
  localparam int C  = 10;
  localparam int CW = $clog2(C);
  // Accumulator width: covers -240..+240 with margin.
  localparam int AW = 10;

  localparam logic [1:0] TW_ZERO = 2'b00;
  localparam logic [1:0] TW_POS  = 2'b01;
  localparam logic [1:0] TW_NEG  = 2'b11;

  // Hidden weights: one 32-bit word per neuron,
  // neuron 0 in the least significant word.
  localparam logic [M*N*2-1:0] PENDIGITS_W1 = {
    32'h74d1_9af8, 32'hc06e_b395, 32'h5b7f_0d24, 32'ha1c3_78fe,
    32'h2d9e_5a13, 32'hf640_cb7d, 32'h8b2d_1f46, 32'h3f75_e9c0,
    32'hd18c_07a5, 32'h62be_f139, 32'h9a07_5dec, 32'h1c3f_b84a,
    32'he965_03db, 32'h4f1a_c7e2, 32'hb3c0_8d69, 32'h7ed4_2b1f,
    32'h05f6_a9c3, 32'hc81b_e574, 32'h39d2_f06b, 32'ha47e_159d,
    32'h6c0f_3b58, 32'h1e93_dac7, 32'hf5b0_4e3c, 32'h8c2d_71b5,
    32'h47f1_e6a2, 32'hd35a_0c9f, 32'h28eb_c371, 32'hb904_5fe6,
    32'h3dc7_92b0, 32'h6a4f_d015, 32'he12c_47f3, 32'h0fd5_6b98,
    32'h73a9_1ec4, 32'hc5d0_3f7a, 32'h1b6f_e243, 32'h9c37_0ad5,
    32'hf04c_95e1, 32'h41dd_7b36, 32'h5e3a_c10f, 32'hd7f1_3c49
  };

  // Output weights: one 80-bit word per class,
  // class 0 in the least significant word.
  localparam logic [C*M*2-1:0] PENDIGITS_W2 = {
    80'he03c_5b92_f7a1_c48d_0b6e,
    80'h6a9f_d41c_2e75_b03d_7f48,
    80'hcd25_73e0_b84f_16a9_5dc3,
    80'h43f1_9ab7_e05c_2d86_f91b,
    80'hb6e8_01d5_c7f3_4a9c_3e52,
    80'h17ca_e350_9fb4_d62e_81a7,
    80'hf24b_8d1e_6c39_0a75_c4e1,
    80'h9d07_4fe3_1bc6_a5d8_27f0,
    80'h3e91_c7a4_0f5d_b268_e3c9,
    80'h5c3d_f017_a94e_6b25_d81c
  };

  // Signed product of a ternary code and an operand;
  // the reserved code contributes nothing.
  function automatic logic signed [AW-1:0] ternary_mac(
    input logic [1:0]           w,
    input logic signed [AW-1:0] x
  );
    logic signed [AW-1:0] r;
    case (w)
      TW_POS:  r = x;
      TW_NEG:  r = -x;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pendigits_tnn_argmax.sv
// Combinational argmax over C signed scores;
// the lowest index wins a tie.
module tnn_argmax
  import pendigits_tnn_pkg::*;
(
  input  logic [C*AW-1:0] i_scores,
  output logic [CW-1:0]   o_idx
);

  logic signed [AW-1:0] w_best;

  // Strict compare keeps the earliest maximum.
  always_comb begin
    o_idx  = '0;
    w_best = i_scores[AW-1:0];
    for (int k = 1; k < C; k++) begin
      if ($signed(i_scores[k*AW +: AW]) > w_best) begin
        w_best = i_scores[k*AW +: AW];
        o_idx  = CW'(k);
      end
    end
  end

endmodule

// File: rtl/pendigits_tnn.sv
// Ternary pen-digits classifier: ternary hidden
// layer, ternary output layer, argmax, one register.
module pendigits_tnn
  import pendigits_tnn_pkg::*;
#(
  parameter logic [M*N*2-1:0] W1 = PENDIGITS_W1,
  parameter logic [C*M*2-1:0] W2 = PENDIGITS_W2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*B-1:0] inp,
  output logic [CW-1:0]  klass
);

  logic [M-1:0]    w_h;
  logic [C*AW-1:0] w_scores;
  logic [CW-1:0]   w_next;

  genvar j, k;

  for (j = 0; j < M; j++) begin : g_hid
    logic signed [AW-1:0] w_acc;
    // Pre-activation of hidden neuron j.
    always_comb begin
      w_acc = '0;
      for (int n = 0; n < N; n++) begin
        w_acc = w_acc + ternary_mac(
          W1[(j*N+n)*2 +: 2],
          {{(AW-B){1'b0}}, inp[n*B +: B]});
      end
    end
    assign w_h[j] = ~w_acc[AW-1];
  end

  for (k = 0; k < C; k++) begin : g_out
    logic signed [AW-1:0] w_sum;
    // Score of class k from binary activations.
    always_comb begin
      w_sum = '0;
      for (int n = 0; n < M; n++) begin
        w_sum = w_sum + ternary_mac(
          W2[(k*M+n)*2 +: 2],
          {{(AW-1){1'b0}}, w_h[n]});
      end
    end
    assign w_scores[k*AW +: AW] = w_sum;
  end

  tnn_argmax u_argmax (
    .i_scores (w_scores),
    .o_idx    (w_next)
  );

  // Register the predicted class every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) klass <= '0;
    else     klass <= w_next;
  end

endmodule

// File: tb/tb_pendigits_tnn.sv
// Directed bench for pendigits_tnn: reset, weight
// overrides, threshold, extremes, trained vectors.
module tb_pendigits_tnn;
  import pendigits_tnn_pkg::*;

  localparam logic [1279:0] W1_Z = '0;
  localparam logic [799:0]  W2_Z = '0;
  localparam logic [799:0]  ROWP = {720'b0, {40{2'b01}}};
  localparam logic [799:0]  W2_R7 = ROWP << (7*80);
  localparam logic [799:0]  W2_R37 = W2_R7 | (ROWP << (3*80));
  localparam logic [1279:0] W1_T = {1278'b0, 2'b11};
  localparam logic [799:0]  W2_T = {798'b0, 2'b01} << 160;
  localparam logic [1279:0] W1_P = {640{2'b01}};
  localparam logic [1279:0] W1_N = {640{2'b11}};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] inp = '0;
  logic [3:0]  k_dflt, k_zero, k_r7, k_tie;
  logic [3:0]  k_thr, k_pos, k_neg;

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] vec [5];

  always #5 clk = ~clk;

  pendigits_tnn u_dflt (
    .clk(clk), .rst(rst), .inp(inp), .klass(k_dflt));
  pendigits_tnn #(.W1(W1_Z), .W2(W2_Z)) u_zero (
    .clk(clk), .rst(rst), .inp(inp), .klass(k_zero));
  pendigits_tnn #(.W1(W1_Z), .W2(W2_R7)) u_r7 (
    .clk(clk), .rst(rst), .inp(inp), .klass(k_r7));
  pendigits_tnn #(.W1(W1_Z), .W2(W2_R37)) u_tie (
    .clk(clk), .rst(rst), .inp(inp), .klass(k_tie));
  pendigits_tnn #(.W1(W1_T), .W2(W2_T)) u_thr (
    .clk(clk), .rst(rst), .inp(inp), .klass(k_thr));
  pendigits_tnn #(.W1(W1_P), .W2(W2_R7)) u_pos (
    .clk(clk), .rst(rst), .inp(inp), .klass(k_pos));
  pendigits_tnn #(.W1(W1_N), .W2(W2_R7)) u_neg (
    .clk(clk), .rst(rst), .inp(inp), .klass(k_neg));

  task automatic chk(input string tag,
                     input logic [3:0] got,
                     input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference classifier written from the math.
  function automatic logic [3:0] golden(
    input logic [63:0]   x,
    input logic [1279:0] w1,
    input logic [799:0]  w2
  );
    int a, s, best, bi;
    logic [1:0] c;
    bit h [40];
    for (int jj = 0; jj < 40; jj++) begin
      a = 0;
      for (int ii = 0; ii < 16; ii++) begin
        c = w1[(jj*16+ii)*2 +: 2];
        if (c == 2'b01) a = a + int'(x[ii*4 +: 4]);
        if (c == 2'b11) a = a - int'(x[ii*4 +: 4]);
      end
      h[jj] = (a >= 0);
    end
    best = -1000;
    bi = 0;
    for (int kk = 0; kk < 10; kk++) begin
      s = 0;
      for (int jj = 0; jj < 40; jj++) begin
        c = w2[(kk*40+jj)*2 +: 2];
        if (h[jj] && c == 2'b01) s = s + 1;
        if (h[jj] && c == 2'b11) s = s - 1;
      end
      if (s > best) begin
        best = s;
        bi = kk;
      end
    end
    return 4'(bi);
  endfunction

  task automatic step(input logic [63:0] v);
    @(negedge clk);
    inp = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec[0] = 64'h8f4d96400498fe6f;
    vec[1] = 64'h0e4f7c572260b0f1;
    vec[2] = 64'h095bceffcc884430;
    vec[3] = 64'h0f1f1b37e5f7c4b0;
    vec[4] = 64'h0b8dffddaa665380;

    inp = vec[0];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold", k_dflt, 4'd0);
    inp = vec[2];
    @(posedge clk);
    #1;
    chk("rst_inp", k_r7, 4'd0);

    @(negedge clk);
    rst = 1'b0;
    inp = vec[0];
    @(posedge clk);
    #1;
    chk("rst_rel", k_dflt, golden(vec[0], PENDIGITS_W1, PENDIGITS_W2));

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async", k_r7, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    step(vec[1]);
    chk("zero_w", k_zero, 4'd0);
    chk("row7", k_r7, 4'd7);
    chk("tie37", k_tie, 4'd3);

    step(64'h0);
    chk("thr_eq0", k_thr, 4'd2);
    step(64'h000000000000000f);
    chk("thr_neg", k_thr, 4'd0);

    step(64'hffffffffffffffff);
    chk("ext_pos", k_pos, 4'd7);
    chk("ext_neg", k_neg, 4'd0);

    for (int v = 0; v < 5; v++) begin
      step(vec[v]);
      chk($sformatf("dflt%0d", v), k_dflt,
          golden(vec[v], PENDIGITS_W1, PENDIGITS_W2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
